// File: rtl/avg_accum_pkg.sv
// rtl/avg_accum_pkg.sv - shared state encoding and block-size/rounding helpers for avg_accum
package avg_accum_pkg;

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  function automatic int calc_n(input int log2n);
    return 1 << log2n;
  endfunction

  // Half of N when rounding; a single-sample block has nothing to round.
  function automatic int calc_bias(input int log2n, input int round);
    return (round != 0 && log2n > 0) ? (1 << (log2n - 1)) : 0;
  endfunction

endpackage

// File: rtl/avg_round_shift.sv
// rtl/avg_round_shift.sv - combinational bias-and-shift turning a block sum into its mean
module avg_round_shift
  import avg_accum_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LOG2N = 1,
  parameter int ROUND = 0
) (
  input  logic [WIDTH+LOG2N-1:0] i_sum,
  output logic [WIDTH-1:0]       o_mean
);

  localparam int SW   = WIDTH + LOG2N;
  localparam int BIAS = calc_bias(LOG2N, ROUND);

  logic [SW-1:0] w_biased;

  // The biased sum stays below N*2**WIDTH, so the shifted value always fits WIDTH bits.
  assign w_biased = i_sum + SW'(BIAS);
  assign o_mean   = WIDTH'(w_biased >> LOG2N);

endmodule

// File: rtl/avg_accum.sv
// rtl/avg_accum.sv - streaming block averager: sums 2**LOG2N samples, emits mean and exact sum
module avg_accum
  import avg_accum_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LOG2N = 1,
  parameter int ROUND = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [WIDTH+LOG2N-1:0] out_sum
);

  localparam int SW = WIDTH + LOG2N;
  localparam int N  = calc_n(LOG2N);
  localparam int CW = (LOG2N == 0) ? 1 : LOG2N;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [0:0]       r_state;
  logic [SW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SW-1:0]    r_out_sum;

  logic [SW-1:0]    w_sum;
  logic [WIDTH-1:0] w_mean;

  assign w_sum = r_acc + SW'(in_data);

  avg_round_shift #(
    .WIDTH (WIDTH),
    .LOG2N (LOG2N),
    .ROUND (ROUND)
  ) u_round_shift (
    .i_sum  (w_sum),
    .o_mean (w_mean)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sum   <= '0;
    end else begin
      case (r_state)
        ST_ACC: begin
          // clr wins over a same-cycle sample, which is silently dropped.
          if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
          end else if (in_valid) begin
            if (r_cnt == CNT_LAST) begin
              r_out_sum   <= w_sum;
              r_out_data  <= w_mean;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_out_valid <= 1'b1;
              r_state     <= ST_HOLD;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_ACC;
          end
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_ACC);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sum   = r_out_sum;

endmodule

// File: tb/tb_avg_accum.sv
// tb/tb_avg_accum.sv - self-checking bench for avg_accum against a block-mean reference model
module tb_avg_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, a_clr, b_clr;
  logic a_in_valid, a_out_ready, b_in_valid, b_out_ready;
  logic [3:0] a_in_data;
  logic [7:0] b_in_data;

  logic       a_in_ready0, a_out_valid0, a_in_ready1, a_out_valid1;
  logic [3:0] a_out_data0, a_out_data1;
  logic [4:0] a_out_sum0, a_out_sum1;
  logic       b_in_ready, b_out_valid;
  logic [7:0] b_out_data;
  logic [9:0] b_out_sum;

  int checks = 0;
  int errors = 0;

  avg_accum #(.WIDTH(4), .LOG2N(1), .ROUND(0)) d0 (
    .clk(clk), .rst(rst), .clr(a_clr), .in_valid(a_in_valid), .in_ready(a_in_ready0),
    .in_data(a_in_data), .out_valid(a_out_valid0), .out_ready(a_out_ready),
    .out_data(a_out_data0), .out_sum(a_out_sum0));

  avg_accum #(.WIDTH(4), .LOG2N(1), .ROUND(1)) d1 (
    .clk(clk), .rst(rst), .clr(a_clr), .in_valid(a_in_valid), .in_ready(a_in_ready1),
    .in_data(a_in_data), .out_valid(a_out_valid1), .out_ready(a_out_ready),
    .out_data(a_out_data1), .out_sum(a_out_sum1));

  avg_accum #(.WIDTH(8), .LOG2N(2), .ROUND(1)) d2 (
    .clk(clk), .rst(rst), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_sum(b_out_sum));

  // Mean of a block of 2**log2n samples by ordinary integer division.
  function automatic int ref_mean(input int sum, input int log2n, input int round);
    int n;
    n = 1 << log2n;
    return (sum + (round != 0 ? n / 2 : 0)) / n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic a_sample(input int d);
    a_in_valid = 1'b1;
    a_in_data  = 4'(d);
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic b_sample(input int d);
    b_in_valid = 1'b1;
    b_in_data  = 8'(d);
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  task automatic a_check_result(input string tag, input int sum);
    check({tag, "_v0"}, 32'(a_out_valid0), 1);
    check({tag, "_v1"}, 32'(a_out_valid1), 1);
    check({tag, "_s0"}, 32'(a_out_sum0), sum);
    check({tag, "_s1"}, 32'(a_out_sum1), sum);
    check({tag, "_m0"}, 32'(a_out_data0), ref_mean(sum, 1, 0));
    check({tag, "_m1"}, 32'(a_out_data1), ref_mean(sum, 1, 1));
    check({tag, "_rdy"}, 32'(a_in_ready0), 0);
  endtask

  task automatic a_drain(input string tag);
    a_out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_drain_v"}, 32'(a_out_valid0), 0);
    check({tag, "_drain_rdy"}, 32'(a_in_ready0), 1);
    a_out_ready = 1'b0;
  endtask

  task automatic a_run(input string tag, input int s0, input int s1, input int hold);
    check({tag, "_start_rdy"}, 32'(a_in_ready0), 1);
    a_out_ready = (hold == 0);
    a_sample(s0);
    a_sample(s1);
    a_check_result(tag, s0 + s1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a_check_result({tag, "_hold"}, s0 + s1);
    end
    a_drain(tag);
  endtask

  task automatic b_run(input string tag, input int s0, input int s1, input int s2,
                       input int s3, input int hold);
    int sum;
    sum = s0 + s1 + s2 + s3;
    check({tag, "_start_rdy"}, 32'(b_in_ready), 1);
    b_out_ready = (hold == 0);
    b_sample(s0);
    b_sample(s1);
    b_sample(s2);
    b_sample(s3);
    for (int i = 0; i <= hold; i++) begin
      check({tag, "_v"}, 32'(b_out_valid), 1);
      check({tag, "_s"}, 32'(b_out_sum), sum);
      check({tag, "_m"}, 32'(b_out_data), ref_mean(sum, 2, 1));
      check({tag, "_rdy"}, 32'(b_in_ready), 0);
      if (i < hold) @(negedge clk);
    end
    b_out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_drain_v"}, 32'(b_out_valid), 0);
    check({tag, "_drain_rdy"}, 32'(b_in_ready), 1);
    b_out_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_a_v"}, 32'(a_out_valid0), 0);
    check({tag, "_a_m"}, 32'(a_out_data0), 0);
    check({tag, "_a_s"}, 32'(a_out_sum0), 0);
    check({tag, "_a_rdy"}, 32'(a_in_ready0), 1);
    check({tag, "_a1_v"}, 32'(a_out_valid1), 0);
    check({tag, "_a1_s"}, 32'(a_out_sum1), 0);
    check({tag, "_b_v"}, 32'(b_out_valid), 0);
    check({tag, "_b_m"}, 32'(b_out_data), 0);
    check({tag, "_b_s"}, 32'(b_out_sum), 0);
    check({tag, "_b_rdy"}, 32'(b_in_ready), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_clr = 1'b0; b_clr = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    a_run("carry", 15, 1, 0);
    a_run("trunc_vs_round", 15, 0, 0);
    a_run("backpressure", 9, 4, 5);

    b_run("no_wrap", 255, 255, 255, 254, 0);
    b_run("small", 1, 2, 2, 2, 0);
    b_run("b_backpressure", 200, 17, 3, 90, 3);

    // Abandon a partial block; the sample offered alongside clr is dropped.
    a_sample(7);
    a_clr = 1'b1; a_in_valid = 1'b1; a_in_data = 4'd9;
    check("clr_rdy", 32'(a_in_ready0), 1);
    @(negedge clk);
    a_clr = 1'b0; a_in_valid = 1'b0;
    a_run("after_clr", 3, 5, 0);

    // clr while a result is pending must not disturb it.
    a_sample(6);
    a_sample(9);
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    a_check_result("clr_in_hold", 15);
    a_drain("clr_in_hold");

    // rst beats a simultaneous drain in HOLD.
    a_sample(12);
    a_sample(13);
    a_out_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; a_out_ready = 1'b0;
    check_reset_state("rst_hold");

    // rst mid-block beats a simultaneous sample.
    a_sample(15);
    rst = 1'b1; a_in_valid = 1'b1; a_in_data = 4'd15;
    @(negedge clk);
    rst = 1'b0; a_in_valid = 1'b0;
    check_reset_state("rst_mid");
    a_run("after_rst", 1, 2, 0);

    for (int i = 0; i < 20; i++) begin
      a_run("rand_a", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)));
      b_run("rand_b", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
